obi_mem_arbiter: RTL
====================

OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of OBI requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, route FIFO depth (1..8).
REQ-005 SHALL have parameter ARB_MODE, default ARB_RR, of type arb_mode_t (ARB_FIXED or ARB_RR).
REQ-006 clk_i  in  1  clock; all state on rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 req_i  in  NUM_PORTS  per-port request.
REQ-009 gnt_o  out  NUM_PORTS  per-port grant.
REQ-010 addr_i / we_i / be_i / wdata_i  in  NUM_PORTS x (ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH)  per-port request fields.
REQ-011 rvalid_o  out  NUM_PORTS  per-port response valid.
REQ-012 rdata_o  out  DATA_WIDTH  response data, shared by all ports.
REQ-013 mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  downstream request.
REQ-014 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1/1/DATA_WIDTH  downstream handshake and response.
REQ-015 err_o  out  1  sticky flag: unexpected response seen.

Function
REQ-016 Winner SHALL be chosen combinationally each cycle from ports with req_i=1.
REQ-017 ARB_FIXED: lowest asserted index SHALL win.
REQ-018 ARB_RR: search SHALL start at (last_grant+1) mod NUM_PORTS and wrap; last_grant SHALL update only on a downstream handshake.
REQ-019 mem_req_o SHALL be 1 iff any req_i=1 and the route FIFO count < MAX_OUTSTANDING; mem_addr/we/be/wdata SHALL be the winner's fields (zero when no request).
REQ-020 gnt_o[winner] SHALL equal mem_req_o & mem_gnt_i; all other gnt_o bits SHALL be 0.
REQ-021 Handshake (mem_req_o & mem_gnt_i) SHALL push the winner index into the route FIFO.
REQ-022 mem_rvalid_i with a non-empty FIFO SHALL pop the head and assert rvalid_o[head] in the same cycle; rdata_o SHALL equal mem_rdata_i.
REQ-023 The full check SHALL use the registered count only; a pop in the same cycle SHALL NOT enable a push when full.
REQ-024 Push and pop in the same cycle with the FIFO non-empty and not full SHALL leave the count unchanged and preserve order.
REQ-025 mem_rvalid_i with an empty FIFO SHALL be ignored (rvalid_o=0), and err_o SHALL be set and held until reset.
REQ-026 Responses SHALL be returned to ports in grant order. Downstream latency SHALL be allowed from 1 cycle upward.
REQ-027 Requesters SHALL hold req_i and fields stable until granted. This is a bench assertion, not checked in RTL.

Reset
REQ-028 Reset SHALL clear FIFO count and pointers, set last_grant to NUM_PORTS-1 so port 0 has first RR priority, and clear err_o.
REQ-029 During reset, gnt_o, rvalid_o and mem_req_o SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL drop all outstanding routes; responses arriving after reset SHALL trigger REQ-025.

Structure
REQ-031 arb_mode_t SHALL live in shared package obi_arb_pkg, together with helper function clog2-based index width.
REQ-032 The route FIFO SHALL be sub-module obi_arb_route_fifo (parametrised depth and width, count output).
REQ-033 No combinational path SHALL exist from mem_rvalid_i to gnt_o.

Verification
REQ-034 ARB_RR, NUM_PORTS=4, all ports requesting continuously, mem_gnt_i=1, latency 1 -> grants 0,1,2,3,0 in consecutive cycles; rvalid_o follows one cycle later in the same order.
REQ-035 ARB_FIXED, ports 1 and 3 requesting -> port 1 is granted each cycle; port 3 is granted only after port 1 deasserts.
REQ-036 MAX_OUTSTANDING=2, latency 4 -> two grants, then mem_req_o=0 until the first mem_rvalid_i; the next grant occurs the cycle after the pop.
REQ-037 Write from port 2 with addr 0x40, be 4'b0101, wdata 0xA5A5A5A5 -> mem_addr_o=0x40, mem_be_o=4'b0101, mem_we_o=1, gnt_o=4'b0100.
REQ-038 mem_rvalid_i pulse with the FIFO empty -> no rvalid_o, err_o=1 persisting until rst_ni is low.
REQ-039 rst_ni pulled low with 2 routes outstanding -> all outputs 0 immediately (asynchronously); after release, port 0 wins first under ARB_RR.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI memory arbiter: arbitration mode and index-width helper.
package obi_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Bits needed to index n items; never below 1 so single-entry ranges stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_arb_route_fifo.sv
// Route FIFO remembering which port owns each outstanding request; head visible combinationally.
// Push into a full FIFO and pop from an empty one are ignored; count is the registered occupancy.
module obi_arb_route_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push_i,
    input  logic [WIDTH-1:0]                     data_i,
    input  logic                                 pop_i,
    output logic [WIDTH-1:0]                     data_o,
    output logic [idx_width(DEPTH+1)-1:0]        count_o
);
    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned CW = idx_width(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/obi_mem_arbiter.sv
// N-to-1 OBI arbiter (fixed or round-robin); zero-cycle request path, responses routed back in grant order.
// Stops requesting downstream while MAX_OUTSTANDING routes are pending; holds each requester until granted.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter arb_mode_t   ARB_MODE        = ARB_RR
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_PORTS-1:0]                   req_i,
    output logic [NUM_PORTS-1:0]                   gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]                   we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]                   rvalid_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
    output logic                                   err_o
);
    localparam int unsigned IW = idx_width(NUM_PORTS);
    localparam int unsigned CW = idx_width(MAX_OUTSTANDING + 1);

    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] winner, cand, head;
    logic [CW-1:0] count;
    logic          found, any_req, full, hs, pop;
    logic          err_q, err_d;

    // Priority search; in RR mode it rotates to start just after the last handshaken port.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (ARB_MODE == ARB_RR) begin
                cand = IW'((32'(last_grant_q) + i + 32'd1) % NUM_PORTS);
            end else begin
                cand = IW'(i);
            end
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Full uses the registered count so a same-cycle response never opens a slot.
    assign any_req   = |req_i;
    assign full      = (count >= CW'(MAX_OUTSTANDING));
    assign mem_req_o = rst_ni && any_req && !full;
    assign hs        = mem_req_o && mem_gnt_i;
    assign pop       = rst_ni && mem_rvalid_i && (count != '0);
    assign rdata_o   = rst_ni ? mem_rdata_i : '0;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        gnt_o       = '0;
        rvalid_o    = '0;
        if (rst_ni && any_req) begin
            mem_addr_o  = addr_i[winner];
            mem_we_o    = we_i[winner];
            mem_be_o    = be_i[winner];
            mem_wdata_o = wdata_i[winner];
        end
        if (hs) begin
            gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            rvalid_o[head] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = hs ? winner : last_grant_q;
        err_d        = err_q || (mem_rvalid_i && (count == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= IW'(NUM_PORTS - 1);
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign err_o = err_q;

    obi_arb_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

endmodule
